// File: rtl/seg7_reader_pkg.sv
// seg7_reader_pkg: segment bit indices, hex glyph table and reader FSM states
package seg7_reader_pkg;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_HA = 7'h77;
  localparam logic [6:0] SEG_HB = 7'h7C;
  localparam logic [6:0] SEG_HC = 7'h39;
  localparam logic [6:0] SEG_HD = 7'h5E;
  localparam logic [6:0] SEG_HE = 7'h79;
  localparam logic [6:0] SEG_HF = 7'h71;
  localparam logic [6:0] GLYPHS [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                         SEG_8, SEG_9, SEG_HA, SEG_HB, SEG_HC, SEG_HD, SEG_HE, SEG_HF};
  typedef enum logic {S_EMPTY, S_TRACK} state_t;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: maps a segment pattern back to its hex digit; hit_o low for non-glyphs
module seg7_decode
  import seg7_reader_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       hit_o,
  output logic [3:0] value_o
);
  always_comb begin
    hit_o = 1'b0;
    value_o = 4'd0;
    for (int i = 0; i < 16; i++)
      if (seg_i == GLYPHS[i]) begin
        hit_o = 1'b1;
        value_o = 4'(i);
      end
  end
endmodule

// File: rtl/seg7_reader.sv
// seg7_reader: debounces a looped-back 7-segment pattern, decodes it and
// checks that successive digits step by +1 mod 16
module seg7_reader
  import seg7_reader_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg_in,
  output logic [3:0]        digit,
  output logic              digit_valid,
  output logic              blank,
  output logic              bad_pattern,
  output logic              skip_err,
  output logic [STEP_W-1:0] step_count
);
  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] STAB_ACC = 8'(STABLE_CYCLES - 1);
  logic [6:0] sync_q, seg_s_q, seg_p_q, last_q, last_d;
  logic [7:0] stab_q, stab_d;
  logic [3:0] digit_q, digit_d, dec_value;
  logic valid_q, valid_d, blank_q, blank_d, bad_q, bad_d, skip_q, skip_d;
  logic [STEP_W-1:0] step_q, step_d;
  state_t state_q, state_d;
  logic same, accept, dec_hit;
  seg7_decode u_decode (.seg_i(seg_s_q), .hit_o(dec_hit), .value_o(dec_value));
  assign same = seg_s_q == seg_p_q;
  // Saturation makes the accept compare true for exactly one cycle per stable run
  assign stab_d = !same ? 8'd0 : (stab_q == STAB_MAX ? stab_q : stab_q + 8'd1);
  assign accept = same && stab_q == STAB_ACC && seg_s_q != last_q;
  always_comb begin
    last_d = last_q;
    digit_d = digit_q;
    blank_d = blank_q;
    step_d = step_q;
    state_d = state_q;
    valid_d = 1'b0;
    bad_d = 1'b0;
    skip_d = 1'b0;
    if (accept) begin
      last_d = seg_s_q;
      if (dec_hit) begin
        digit_d = dec_value;
        valid_d = 1'b1;
        blank_d = 1'b0;
        state_d = S_TRACK;
        if (state_q == S_TRACK) begin
          step_d = dec_value == digit_q + 4'd1 ? step_q + 1'b1 : step_q;
          skip_d = dec_value != digit_q + 4'd1;
        end
      end else begin
        blank_d = seg_s_q == SEG_BLANK ? 1'b1 : blank_q;
        bad_d = seg_s_q != SEG_BLANK;
        state_d = S_EMPTY;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= SEG_BLANK;
      seg_s_q <= SEG_BLANK;
      seg_p_q <= SEG_BLANK;
      last_q <= SEG_BLANK;
      stab_q <= 8'd0;
      digit_q <= 4'd0;
      valid_q <= 1'b0;
      blank_q <= 1'b1;
      bad_q <= 1'b0;
      skip_q <= 1'b0;
      step_q <= '0;
      state_q <= S_EMPTY;
    end else begin
      sync_q <= seg_in;
      seg_s_q <= sync_q;
      seg_p_q <= seg_s_q;
      last_q <= last_d;
      stab_q <= stab_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      blank_q <= blank_d;
      bad_q <= bad_d;
      skip_q <= skip_d;
      step_q <= step_d;
      state_q <= state_d;
    end
  assign digit = digit_q;
  assign digit_valid = valid_q;
  assign blank = blank_q;
  assign bad_pattern = bad_q;
  assign skip_err = skip_q;
  assign step_count = step_q;
endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: directed loopback stimulus checked every cycle against a
// run-length behavioural model, plus hand-computed literal expectations
module tb_seg7_reader;
  localparam int STABLE = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] seg_in = 7'h00;
  logic [3:0] digit;
  logic digit_valid, blank, bad_pattern, skip_err;
  logic [7:0] step_count;
  int total = 0, bad = 0;
  int n_valid = 0, n_skip = 0, n_bad = 0;
  seg7_reader #(.STABLE_CYCLES(STABLE), .STEP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .digit(digit), .digit_valid(digit_valid),
    .blank(blank), .bad_pattern(bad_pattern), .skip_err(skip_err), .step_count(step_count));
  always #5 clk = ~clk;
  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  // Model: a pattern is taken when it has been seen on exactly STABLE+1
  // consecutive synchronized samples and differs from the last one taken
  logic [6:0] d1, d2, cur, prev, last;
  int run, idx;
  logic [3:0] m_digit;
  logic [7:0] m_steps;
  logic m_valid, m_blank, m_bad, m_skip, have_ref;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d1 = 0; d2 = 0; prev = 0; last = 0; run = 1; have_ref = 0;
      m_digit = 0; m_steps = 0; m_blank = 1; m_valid = 0; m_bad = 0; m_skip = 0;
    end else begin
      cur = d2;
      run = cur == prev ? (run < 1000 ? run + 1 : run) : 1;
      prev = cur;
      m_valid = 0; m_bad = 0; m_skip = 0;
      if (run == STABLE + 1 && cur != last) begin
        last = cur;
        idx = -1;
        for (int i = 0; i < 16; i++) if (tbl[i] == cur) idx = i;
        if (idx >= 0) begin
          if (have_ref && idx == (int'(m_digit) + 1) % 16) m_steps = m_steps + 1;
          else if (have_ref) m_skip = 1;
          m_digit = 4'(idx); m_valid = 1; m_blank = 0; have_ref = 1;
        end else if (cur == 0) begin
          m_blank = 1; have_ref = 0;
        end else begin
          m_bad = 1; have_ref = 0;
        end
      end
      d2 = d1; d1 = seg_in;
    end
  always @(negedge clk)
    if (rst_n) begin
      total++;
      if ({digit, digit_valid, blank, bad_pattern, skip_err, step_count} !==
          {m_digit, m_valid, m_blank, m_bad, m_skip, m_steps}) begin
        bad++;
        $display("FAIL cycle_model t=%0t got digit=%h v=%b blank=%b bad=%b skip=%b steps=%0d want digit=%h v=%b blank=%b bad=%b skip=%b steps=%0d",
                 $time, digit, digit_valid, blank, bad_pattern, skip_err, step_count,
                 m_digit, m_valid, m_blank, m_bad, m_skip, m_steps);
      end
      n_valid += int'(digit_valid); n_skip += int'(skip_err); n_bad += int'(bad_pattern);
    end
  task automatic lit(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask
  task automatic hold(input logic [6:0] p, input int n);
    seg_in = p;
    repeat (n) @(negedge clk);
  endtask
  int v0, s0, b0, st0;
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1;
    lit("reset_digit", digit, 0); lit("reset_blank", blank, 1); lit("reset_steps", step_count, 0);
    v0 = n_valid; s0 = n_skip;
    hold(7'h06, 10);
    lit("first_digit", digit, 1); lit("first_valid", n_valid - v0, 1); lit("first_noskip", n_skip - s0, 0);
    seg_in = 7'h5B;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      lit($sformatf("latency_edge%0d", k), digit_valid, k == 6 ? 1 : 0);
    end
    lit("latency_digit", digit, 2); lit("latency_steps", step_count, 1);
    hold(7'h3F, 10);
    v0 = n_valid;
    hold(7'h06, 3);
    hold(7'h3F, 12);
    lit("glitch_nopulse", n_valid - v0, 0); lit("glitch_digit", digit, 0);
    hold(7'h00, 10);
    lit("blank_level", blank, 1);
    v0 = n_valid; s0 = n_skip; st0 = step_count;
    for (int i = 0; i < 16; i++) hold(tbl[i], 10);
    hold(7'h3F, 10);
    lit("seq_valid", n_valid - v0, 17); lit("seq_steps", step_count - st0, 16);
    lit("seq_noskip", n_skip - s0, 0); lit("seq_steps_abs", step_count, 17);
    lit("model_steps_abs", m_steps, 17); lit("seq_digit", digit, 0);
    hold(7'h06, 10);
    s0 = n_skip; st0 = step_count;
    hold(7'h4F, 10);
    lit("skip_pulse", n_skip - s0, 1); lit("skip_digit", digit, 3); lit("skip_steps", step_count, st0);
    hold(7'h66, 10);
    lit("after_skip_steps", step_count, st0 + 1); lit("model_after_skip", m_steps, 19);
    b0 = n_bad; v0 = n_valid;
    hold(7'h01, 10);
    lit("bad_pulse", n_bad - b0, 1); lit("bad_digit_hold", digit, 4); lit("bad_blank_hold", blank, 0);
    hold(7'h00, 10);
    lit("blank_after_bad", blank, 1); lit("blank_digit_hold", digit, 4);
    s0 = n_skip;
    hold(7'h06, 10);
    lit("empty_valid", n_valid - v0, 1); lit("empty_noskip", n_skip - s0, 0); lit("empty_digit", digit, 1);
    seg_in = 7'h5B;
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    seg_in = 7'h00;
    #1;
    lit("midreset_digit", digit, 0); lit("midreset_blank", blank, 1); lit("midreset_steps", step_count, 0);
    lit("midreset_pulses", {digit_valid, bad_pattern, skip_err}, 0);
    @(negedge clk);
    rst_n = 1;
    v0 = n_valid; b0 = n_bad;
    hold(7'h00, 12);
    lit("post_reset_quiet", n_valid - v0 + n_bad - b0, 0);
    s0 = n_skip;
    hold(7'h06, 10);
    lit("post_reset_digit", digit, 1); lit("post_reset_valid", n_valid - v0, 1);
    lit("post_reset_noskip", n_skip - s0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
